// File: rtl/flex_spi_slave.sv
`timescale 1ns/1ps
// flex_spi_slave: SPI target that shifts a 1..WIDTH bit word MSB-first in all four CPOL/CPHA modes.
// Latency: a pin edge takes effect 4 clk later (2-flop sync, edge flop, pulse flop); done 1 clk after last sample.
// Backpressure: none; the host reads rx_reg via oe before the next done (overrun flag when enabled).
//
// Ports: clk/rst (sync, active-high); ss/sck/mosi async serial inputs; miso serial out (z when idle);
//        en gates ss; oe/we share the bidirectional data bus (we wins); cpol/cpha/xfer_len set the frame;
//        busy is high from LOAD through DONE; done pulses for one clk per received word.
// Optional: define FLEX_SPI_SLAVE_OVERRUN_EN to add the overrun output and the rx_valid tracking.

module flex_spi_slave #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ss,
  input  logic             sck,
  input  logic             mosi,
  output logic             miso,
  input  logic             en,
  input  logic             oe,
  input  logic             we,
  input  logic             cpol,
  input  logic             cpha,
  input  logic [3:0]       xfer_len,
  output logic             busy,
  output logic             done,
  inout  wire  [WIDTH-1:0] data
`ifdef FLEX_SPI_SLAVE_OVERRUN_EN
  ,
  output logic             overrun
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;

  // Synchronisers; the third sck/mosi flop keeps mosi aligned with the edge compare.
  logic             ss_s1, ss_s2;
  logic             sck_s1, sck_s2, sck_s3;
  logic             mosi_s1, mosi_s2, mosi_s3;
  logic             lead_p, trail_p;

  logic [WIDTH-1:0] tx_reg, rx_reg;
  logic [WIDTH-1:0] tx_sh, rx_sh;
  logic [3:0]       bit_cnt;
  logic             miso_q, miso_oe;
  // High from LOAD until the first leading edge of the word.
  logic             first_edge;

  logic             abort;
  logic             do_sample, do_shift;
  logic [WIDTH-1:0] rx_next, tx_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      ss_s1   <= 1'b1;
      ss_s2   <= 1'b1;
      sck_s1  <= cpol;
      sck_s2  <= cpol;
      sck_s3  <= cpol;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
      mosi_s3 <= 1'b0;
      lead_p  <= 1'b0;
      trail_p <= 1'b0;
    end else begin
      ss_s1   <= ss;
      ss_s2   <= ss_s1;
      sck_s1  <= sck;
      sck_s2  <= sck_s1;
      sck_s3  <= sck_s2;
      mosi_s1 <= mosi;
      mosi_s2 <= mosi_s1;
      mosi_s3 <= mosi_s2;
      // Leading edge leaves the idle level, trailing edge returns to it.
      lead_p  <= (sck_s3 == cpol) && (sck_s2 != cpol);
      trail_p <= (sck_s3 != cpol) && (sck_s2 == cpol);
    end
  end

  always_comb begin
    abort     = ss_s2 || !en;
    do_sample = cpha ? trail_p : lead_p;
    // Nothing is shifted out before the first leading edge: in mode cpha=1 that edge keeps the
    // LOAD bit, and in cpha=0 it swallows the trailing edge that closes a previous streamed word.
    do_shift  = (cpha ? lead_p : trail_p) && !first_edge;
    rx_next   = {rx_sh[WIDTH-2:0], mosi_s3};
    tx_next   = tx_sh << 1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tx_reg     <= '0;
      rx_reg     <= '0;
      tx_sh      <= '0;
      rx_sh      <= '0;
      bit_cnt    <= 4'd0;
      miso_q     <= 1'b0;
      miso_oe    <= 1'b0;
      first_edge <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      // A write during a word only affects the next LOAD.
      if (we) tx_reg <= data;
      case (state)
        IDLE: begin
          miso_oe <= 1'b0;
          if (en && !ss_s2) state <= LOAD;
        end
        LOAD: begin
          if (abort) begin
            state   <= IDLE;
            miso_oe <= 1'b0;
          end else begin
            tx_sh      <= tx_reg;
            rx_sh      <= '0;
            bit_cnt    <= 4'd0;
            miso_q     <= tx_reg[xfer_len];
            miso_oe    <= 1'b1;
            first_edge <= 1'b1;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          if (abort) begin
            state   <= IDLE;
            miso_oe <= 1'b0;
          end else begin
            if (lead_p) first_edge <= 1'b0;
            if (do_sample) begin
              rx_sh   <= rx_next;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == xfer_len) begin
                // rx_sh was cleared in LOAD, so bits above xfer_len arrive as zero.
                state  <= DONE;
                done   <= 1'b1;
                rx_reg <= rx_next;
              end
            end
            if (do_shift) begin
              tx_sh  <= tx_next;
              miso_q <= tx_next[xfer_len];
            end
          end
        end
        DONE: begin
          if (!ss_s2) begin
            state <= LOAD;
          end else begin
            state   <= IDLE;
            miso_oe <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign miso = miso_oe ? miso_q : 1'bz;
  assign data = (oe && !we) ? rx_reg : {WIDTH{1'bz}};

`ifdef FLEX_SPI_SLAVE_OVERRUN_EN
  logic rx_valid;

  // A completion in the same cycle as a read takes priority and leaves the word unread.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else if (state == DONE) begin
      rx_valid <= 1'b1;
      if (rx_valid) overrun <= 1'b1;
    end else if (oe && !we) begin
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_flex_spi_slave.sv
`timescale 1ns/1ps
// tb_flex_spi_slave: directed vectors for flex_spi_slave; a bench-side SPI master drives sck/mosi.
// Latency: bench drives and samples on clk negedges, sck half-period 4 clk.
// Backpressure: n/a.

module tb_flex_spi_slave;

  localparam int H = 4;  // sck half-period in clk cycles

  logic        clk = 1'b0;
  logic        rst, ss, sck, mosi, en, oe, we, cpol, cpha;
  logic [3:0]  xfer_len;
  wire         miso;
  logic        busy, done;
  wire  [15:0] data;
  logic [15:0] data_drv;
  logic        data_en;
`ifdef FLEX_SPI_SLAVE_OVERRUN_EN
  logic        overrun;
`endif

  assign data = data_en ? data_drv : 16'bz;

  flex_spi_slave #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .ss       (ss),
    .sck      (sck),
    .mosi     (mosi),
    .miso     (miso),
    .en       (en),
    .oe       (oe),
    .we       (we),
    .cpol     (cpol),
    .cpha     (cpha),
    .xfer_len (xfer_len),
    .busy     (busy),
    .done     (done),
    .data     (data)
`ifdef FLEX_SPI_SLAVE_OVERRUN_EN
    ,
    .overrun  (overrun)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  initial begin
    #500us;
    $display("FAIL timeout: simulation did not finish (errors=%0d)", errors);
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Bench master: sends bits len..len-nbits+1 of w, returns what it sampled on miso.
  task automatic master_word(input logic [15:0] w, input int len, input int nbits,
                             output logic [15:0] got);
    got = '0;
    for (int k = 0; k < nbits; k++) begin
      int i;
      i = len - k;
      if (!cpha) begin
        mosi = w[i];
        repeat (H) @(negedge clk);
        got[i] = miso;
        sck = ~cpol;
        repeat (H) @(negedge clk);
        sck = cpol;
      end else begin
        sck  = ~cpol;
        mosi = w[i];
        repeat (H) @(negedge clk);
        got[i] = miso;
        sck = cpol;
        repeat (H) @(negedge clk);
      end
    end
  endtask

  task automatic do_word(input logic [15:0] w, output logic [15:0] got);
    ss = 1'b0;
    repeat (6) @(negedge clk);
    master_word(w, int'(xfer_len), int'(xfer_len) + 1, got);
    repeat (2) @(negedge clk);
    ss = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic read_rx(output logic [15:0] v);
    oe = 1'b1;
    we = 1'b0;
    #1 v = data;
    @(negedge clk);
    oe = 1'b0;
  endtask

  task automatic we_load(input logic [15:0] val, input logic with_oe);
    data_drv = val;
    data_en  = 1'b1;
    we       = 1'b1;
    oe       = with_oe;
    #1;
    if (with_oe) chk("we_over_oe_bus", data, val);
    @(negedge clk);
    we      = 1'b0;
    oe      = 1'b0;
    data_en = 1'b0;
  endtask

  typedef struct {
    logic        cpol;
    logic        cpha;
    logic [3:0]  len;
    logic [15:0] tx;
    logic [15:0] mo;
    logic [15:0] exp_miso;
    logic [15:0] exp_rx;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [15:0] got, got2, r;
    int d0;

    vecs[0] = '{1'b0, 1'b1, 4'd12, 16'hAAAA, 16'h1FFF, 16'h0AAA, 16'h1FFF};
    vecs[1] = '{1'b0, 1'b0, 4'd15, 16'h5A3C, 16'hC3A5, 16'h5A3C, 16'hC3A5};
    vecs[2] = '{1'b1, 1'b0, 4'd3,  16'hFFF9, 16'h0006, 16'h0009, 16'h0006};
    vecs[3] = '{1'b1, 1'b1, 4'd0,  16'h0001, 16'h0001, 16'h0001, 16'h0001};
    vecs[4] = '{1'b0, 1'b1, 4'd7,  16'h00C3, 16'h005A, 16'h00C3, 16'h005A};

    rst = 1'b1; ss = 1'b1; sck = 1'b0; mosi = 1'b0; en = 1'b1;
    oe = 1'b0; we = 1'b0; cpol = 1'b0; cpha = 1'b0; xfer_len = 4'd15;
    data_drv = '0; data_en = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("reset_busy", {15'd0, busy}, 16'd0);
    chk("reset_done", {15'd0, done}, 16'd0);
    read_rx(r);
    chk("reset_rx", r, 16'h0000);

    // Single words across modes and lengths
    foreach (vecs[k]) begin
      cpol = vecs[k].cpol; cpha = vecs[k].cpha; xfer_len = vecs[k].len;
      sck = vecs[k].cpol;
      we_load(vecs[k].tx, 1'b0);
      repeat (8) @(negedge clk);
      d0 = done_cnt;
      do_word(vecs[k].mo, got);
      chk($sformatf("v%0d_miso", k), got, vecs[k].exp_miso);
      chk($sformatf("v%0d_done", k), 16'(done_cnt - d0), 16'd1);
      read_rx(r);
      chk($sformatf("v%0d_rx", k), r, vecs[k].exp_rx);
    end

    // Mode 3 back-to-back words; tx written mid word 1 (with oe also high)
    cpol = 1'b1; cpha = 1'b1; xfer_len = 4'd7; sck = 1'b1;
    we_load(16'h0055, 1'b0);
    repeat (8) @(negedge clk);
    d0 = done_cnt;
    ss = 1'b0;
    repeat (6) @(negedge clk);
    fork
      master_word(16'h0081, 7, 8, got);
      begin
        repeat (10) @(negedge clk);
        we_load(16'h00F0, 1'b1);
      end
    join
    read_rx(r);
    chk("b2b_rx1", r, 16'h0081);
    master_word(16'h007E, 7, 8, got2);
    repeat (2) @(negedge clk);
    ss = 1'b1;
    repeat (6) @(negedge clk);
    read_rx(r);
    chk("b2b_rx2", r, 16'h007E);
    chk("b2b_miso1", got, 16'h0055);
    chk("b2b_miso2", got2, 16'h00F0);
    chk("b2b_done", 16'(done_cnt - d0), 16'd2);

    // Abort after 5 bits
    cpol = 1'b0; cpha = 1'b0; xfer_len = 4'd15; sck = 1'b0;
    repeat (8) @(negedge clk);
    d0 = done_cnt;
    ss = 1'b0;
    repeat (6) @(negedge clk);
    master_word(16'hFFFF, 15, 5, got);
    chk("abort_busy_mid", {15'd0, busy}, 16'd1);
    ss = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_busy_after", {15'd0, busy}, 16'd0);
    repeat (4) @(negedge clk);
    chk("abort_done", 16'(done_cnt - d0), 16'd0);
    read_rx(r);
    chk("abort_rx_kept", r, 16'h007E);

    // Reset in mid-word, then a clean word (tx_reg must be back to zero)
    d0 = done_cnt;
    ss = 1'b0;
    repeat (6) @(negedge clk);
    master_word(16'hFFFF, 15, 7, got);
    rst = 1'b1;
    ss  = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_done", {15'd0, done}, 16'd0);
    read_rx(r);
    chk("rst_rx", r, 16'h0000);
    chk("rst_no_done", 16'(done_cnt - d0), 16'd0);
    repeat (6) @(negedge clk);
    d0 = done_cnt;
    do_word(16'h1234, got);
    chk("post_rst_miso", got, 16'h0000);
    chk("post_rst_done", 16'(done_cnt - d0), 16'd1);
    read_rx(r);
    chk("post_rst_rx", r, 16'h1234);

`ifdef FLEX_SPI_SLAVE_OVERRUN_EN
    // Two words without a read in between
    xfer_len = 4'd7;
    repeat (4) @(negedge clk);
    do_word(16'h0011, got);
    chk("ovr_after_w1", {15'd0, overrun}, 16'd0);
    do_word(16'h0022, got);
    chk("ovr_after_w2", {15'd0, overrun}, 16'd1);
    read_rx(r);
    chk("ovr_rx", r, 16'h0022);
    chk("ovr_cleared", {15'd0, overrun}, 16'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
